// File: rtl/line_fill_seq.sv
// line_fill_seq
//   Cache line fill / write-back sequencer. On a miss it can first write the
//   4-word dirty victim line back to main memory, then reads the requested
//   4-word line, writes every word into the cache data array and captures the
//   requested word into req_data for the memory stage.
//
// Parameters
//   MEM_LAT      fixed memory read latency, mem_rd issue to valid mem_rdata (1..4)
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   start        begin a sequence (sampled only in IDLE)
//   wb           with start: write the victim line back before the fill
//   addr         requested byte address (line = addr[15:3], word = addr[2:1])
//   victim_base  victim line address, used when wb=1
//   cache_rdata  cache word selected by cache_offset (same cycle)
//   mem_rdata    memory read data
//   mem_addr     memory word address
//   mem_rd       memory read strobe
//   mem_wr       memory write strobe
//   mem_wdata    memory write data
//   cache_offset word select into the cache line
//   cache_wr     cache write strobe
//   cache_wdata  cache write data
//   req_data     captured requested word
//   busy         sequence in progress
//   done         one-cycle completion pulse
//
// States
//   IDLE | waiting for start
//   WB   | victim line write-back, one word per cycle (cnt 0..3)
//   RD   | line read issue (cnt 0..3) overlapped with cache fill
//        | (cnt MEM_LAT..MEM_LAT+3)
//   DONE | completion pulse, back to IDLE next cycle

module line_fill_seq #(
  parameter int MEM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        wb,
  input  logic [15:0] addr,
  input  logic [12:0] victim_base,
  input  logic [15:0] cache_rdata,
  input  logic [15:0] mem_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  cache_offset,
  output logic        cache_wr,
  output logic [15:0] cache_wdata,
  output logic [15:0] req_data,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WB   = 2'd1,
    S_RD   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAT      = 4'(MEM_LAT);
  localparam logic [3:0] FILL_END = 4'(MEM_LAT + 4);
  localparam logic [3:0] RD_LAST  = 4'(MEM_LAT + 3);
  localparam logic [3:0] WB_LAST  = 4'd3;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [15:1] addr_q;
  logic [12:0] victim_q;
  logic [3:0]  fill_idx;
  logic        rd_issue;
  logic        rd_fill;

  // The write-back decision is taken on the start edge itself, so wb only
  // steers the IDLE exit and needs no register of its own.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start) state_nxt = wb ? S_WB : S_RD;
      S_WB:   if (cnt == WB_LAST) state_nxt = S_RD;
      S_RD:   if (cnt == RD_LAST) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      addr_q   <= '0;
      victim_q <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= 4'd0;
      end else if (state == S_WB || state == S_RD) begin
        cnt <= cnt + 4'd1;
      end
      if (state == S_IDLE && start) begin
        addr_q   <= addr[15:1];
        victim_q <= victim_base;
      end
    end
  end

  // Read issue covers the first four RD cycles; fill trails it by MEM_LAT.
  assign fill_idx = cnt - LAT;
  assign rd_issue = (state == S_RD) && (cnt < 4'd4);
  assign rd_fill  = (state == S_RD) && (cnt >= LAT) && (cnt < FILL_END);

  always_comb begin
    mem_rd       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'd0;
    mem_wdata    = 16'd0;
    cache_wr     = 1'b0;
    cache_offset = 2'd0;
    cache_wdata  = 16'd0;
    if (state == S_WB) begin
      mem_wr       = 1'b1;
      mem_addr     = {victim_q, cnt[1:0], 1'b0};
      cache_offset = cnt[1:0];
      mem_wdata    = cache_rdata;
    end
    if (rd_issue) begin
      mem_rd   = 1'b1;
      mem_addr = {addr_q[15:3], cnt[1:0], 1'b0};
    end
    if (rd_fill) begin
      cache_wr     = 1'b1;
      cache_offset = fill_idx[1:0];
      cache_wdata  = mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_data <= 16'd0;
    end else if (rd_fill && (fill_idx[1:0] == addr_q[2:1])) begin
      req_data <= mem_rdata;
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule
